tdm_mux_8to1: RTL

- Eight-channel to one-stream round-robin multiplexer with registered output.
- Merges eight independent valid/ready input streams onto one output stream.
- Tags each beat with a 3-bit channel code `op_s`, so a downstream 3:8 demultiplexer can route the beat back to its lane.
- Sits at the transmit end of the shared channel link.

---
 rtl/tdm_mux_8to1.sv | 84 ++++++++
 1 files changed

// File: rtl/tdm_mux_8to1.sv
// Eight-lane round-robin multiplexer onto one registered valid/ready stream.
// Each output beat carries a 3-bit channel code for the far-end demultiplexer.
module tdm_mux_8to1 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            ch_en,
  input  logic [8*DATA_W-1:0]   ip_data,
  input  logic [7:0]            ip_valid,
  output logic [7:0]            ip_ready,
  output logic [DATA_W-1:0]     op_data,
  output logic [2:0]            op_s,
  output logic                  op_valid,
  input  logic                  op_ready
);

  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic [2:0]        op_s_q, op_s_d;
  logic              op_valid_q, op_valid_d;
  logic [2:0]        ptr_q, ptr_d;

  logic [7:0] req;
  logic       load;
  logic       found;
  logic [2:0] grant_idx;
  logic [2:0] cand;
  logic       xfer;

  assign req  = ip_valid & ch_en;
  assign load = ~op_valid_q | op_ready;

  // Search starts at ptr_q; 3-bit index arithmetic provides the 7->0 wrap.
  always_comb begin
    found     = 1'b0;
    grant_idx = 3'd0;
    cand      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // No channel is acked while reset is asserted.
  assign xfer     = load & found & ~rst;
  assign ip_ready = xfer ? (8'b1 << grant_idx) : 8'b0;

  always_comb begin
    op_data_d  = op_data_q;
    op_s_d     = op_s_q;
    op_valid_d = op_valid_q;
    ptr_d      = ptr_q;
    if (rst) begin
      op_data_d  = '0;
      op_s_d     = 3'd0;
      op_valid_d = 1'b0;
      ptr_d      = 3'd0;
    end else if (load) begin
      if (found) begin
        op_data_d  = ip_data[grant_idx*DATA_W +: DATA_W];
        op_s_d     = grant_idx;
        op_valid_d = 1'b1;
        ptr_d      = grant_idx + 3'd1;
      end else begin
        op_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    op_data_q  <= op_data_d;
    op_s_q     <= op_s_d;
    op_valid_q <= op_valid_d;
    ptr_q      <= ptr_d;
  end

  assign op_data  = op_data_q;
  assign op_s     = op_s_q;
  assign op_valid = op_valid_q;

endmodule
